nibble_serial_subtractor: RTL and testbench

Multi-cycle WIDTH-bit subtractor computing diff = a − b − bin. It processes one 4-bit nibble per clock, LSB first, through a 4-bit borrow-lookahead slice. It is the subtract-direction companion to the team's 4-bit carry-lookahead adder. It sits behind a start/busy/done handshake so a sequencer can reuse one narrow slice for wide operands.

---
 rtl/nibble_sub_pkg.sv | 21 ++
 rtl/bla_sub_4bit.sv | 39 +++
 rtl/nibble_serial_subtractor.sv | 150 +++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_sub_pkg.sv
// rtl/nibble_sub_pkg.sv - shared constants, state type and sizing helper for the nibble-serial subtractor
//
// Purpose: common definitions imported by bla_sub_4bit and nibble_serial_subtractor.
//   NIBBLE       : width of the arithmetic slice in bits
//   state_e      : sequencer states IDLE / RUN / DONE
//   nibble_count : number of slice passes needed for a given operand width
package nibble_sub_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/bla_sub_4bit.sv
// rtl/bla_sub_4bit.sv - combinational 4-bit borrow-lookahead subtract slice
//
// Purpose: d = x - y - bi over four bits with all internal borrows resolved
//          by lookahead rather than rippling.
// Ports:
//   x  [3:0] in  : minuend nibble
//   y  [3:0] in  : subtrahend nibble
//   bi       in  : borrow-in
//   d  [3:0] out : difference nibble
//   bo       out : borrow-out
module bla_sub_4bit
  import nibble_sub_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  // A bit generates a borrow when x=0,y=1 and passes an incoming borrow when x==y.
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign c[0] = bi;
  assign c[1] = g[0] | (p[0] & bi);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d  = x ^ y ^ c[3:0];
  assign bo = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle WIDTH-bit subtractor, one nibble per clock, LSB first
//
// Purpose: diff = a - b - bin computed through a single bla_sub_4bit slice,
//          sequenced by a start/busy/done handshake.
// Optional build macro: NIBBLE_SUB_ADD_MODE_EN adds the op input
//          (op=1 : diff = a + b + bin, bout reports carry-out).
// Ports:
//   clk       in  : rising-edge clock
//   rst_n     in  : asynchronous active-low reset
//   start     in  : operation request, sampled only in IDLE
//   op        in  : (macro only) 0 = subtract, 1 = add, captured with start
//   a, b      in  : operands, captured on accepted start
//   bin       in  : borrow-in (carry-in when adding), captured on accepted start
//   busy      out : high while nibbles are being processed
//   done      out : one-cycle pulse when the result is valid
//   diff      out : result, held until the next accepted start
//   bout      out : final borrow (carry in add mode)
//   zero      out : diff == 0
//   overflow  out : signed overflow
module nibble_serial_subtractor
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NIBBLE_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             overflow
);

  localparam int NN = nibble_count(WIDTH);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  generate
    if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_e           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] diff_next;
  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       d_nib;
  logic             bo_nib;

  // Add mode reuses the subtract slice: a + b + c == a - ~b - ~c (mod 2^WIDTH),
  // and the slice's final borrow is then the inverse of the carry-out.
  logic inv_in;
  logic add_q;

`ifdef NIBBLE_SUB_ADD_MODE_EN
  assign inv_in = op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q <= 1'b0;
    end else if (state == IDLE && start) begin
      add_q <= op;
    end
  end
`else
  assign inv_in = 1'b0;
  assign add_q  = 1'b0;
`endif

  assign x_nib = a_reg[idx*NIBBLE +: NIBBLE];
  assign y_nib = b_reg[idx*NIBBLE +: NIBBLE];

  bla_sub_4bit u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .bi (borrow),
    .d  (d_nib),
    .bo (bo_nib)
  );

  // Result including the nibble being finished this cycle, so the flags can
  // be registered on the same edge as the last nibble.
  always_comb begin
    diff_next = diff;
    diff_next[idx*NIBBLE +: NIBBLE] = d_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      borrow   <= 1'b0;
      idx      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= inv_in ? ~b : b;
            borrow   <= bin ^ inv_in;
            idx      <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff   <= diff_next;
          borrow <= bo_nib;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            state <= DONE;
            bout  <= bo_nib ^ add_q;
            zero  <= (diff_next == '0);
            // b_reg holds ~b in add mode, so "a and b_reg signs differ" is the
            // subtract rule and, equivalently, the add rule "a and b signs match".
            overflow <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - self-checking scoreboard bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

  localparam int W  = 16;
  localparam int NN = W / 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef NIBBLE_SUB_ADD_MODE_EN
    .op       (op),
`endif
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .overflow (overflow)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic o);
    logic [W:0] full;
    res_t       r;
    if (o) full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    else   full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
    r.diff = full[W-1:0];
    r.bout = full[W];
    r.zero = (r.diff == '0);
    if (o) r.ovf = (x[W-1] == y[W-1]) && (r.diff[W-1] != x[W-1]);
    else   r.ovf = (x[W-1] != y[W-1]) && (r.diff[W-1] != x[W-1]);
    return r;
  endfunction

  // Leaves any DONE cycle first, then presents a request and records its expected result.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic o);
    @(posedge clk); #1;
    exp_q.push_back(model(x, y, ci, o));
    a = x; b = y; bin = ci; op = o; start = 1'b1;
  endtask

  // Called just after the accepting edge; edges counts that edge as 1. -1 means timeout.
  task automatic wait_done(output int edges, output int busy_hi);
    edges   = 1;
    busy_hi = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_hi++;
      @(posedge clk); #1;
      edges++;
    end
    if (done !== 1'b1) edges = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, bout, zero, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, expected all 0",
               busy, done, diff, bout, zero, overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic o, input bit check_hold);
    int   e, bh;
    res_t got, ex;
    issue(x, y, ci, o);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(e, bh);
    got = {diff, bout, zero, overflow};
    ex  = exp_q.pop_front();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s_result: got diff=%h bout=%b zero=%b ovf=%b, expected diff=%h bout=%b zero=%b ovf=%b",
               name, got.diff, got.bout, got.zero, got.ovf, ex.diff, ex.bout, ex.zero, ex.ovf);
    end
    checks++;
    if (e !== NN + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, expected %0d", name, e, NN + 1);
    end
    if (check_hold) begin
      checks++;
      if (bh !== NN) begin
        errors++;
        $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, bh, NN);
      end
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL %s_done_pulse: got done=%b busy=%b, expected 0 0", name, done, busy);
      end
      checks++;
      if ({diff, bout, zero, overflow} !== ex) begin
        errors++;
        $display("FAIL %s_hold: got diff=%h bout=%b zero=%b ovf=%b, expected diff=%h",
                 name, diff, bout, zero, overflow, ex.diff);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int   e, bh;
    res_t ex;
    issue(16'h5555, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    // Keep a different request asserted through RUN and the DONE cycle.
    a = 16'hFFFF; b = 16'hFFFF; bin = 1'b1; start = 1'b1;
    wait_done(e, bh);
    start = 1'b0;
    ex = exp_q.pop_front();
    checks++;
    if (diff !== ex.diff || bout !== ex.bout) begin
      errors++;
      $display("FAIL busy_ignore_result: got diff=%h bout=%b, expected diff=%h bout=%b",
               diff, bout, ex.diff, ex.bout);
    end
    checks++;
    if (e !== NN + 1) begin
      errors++;
      $display("FAIL busy_ignore_latency: got %0d edges, expected %0d", e, NN + 1);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00 || diff !== 16'h4444) begin
      errors++;
      $display("FAIL busy_ignore_no_restart: got busy=%b done=%b diff=%h, expected 0 0 4444",
               busy, done, diff);
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    @(posedge clk); #1;
    a = 16'h9876; b = 16'h1234; bin = 1'b0; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout, zero, overflow} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, expected all 0",
               busy, done, diff, bout, zero, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
    end
    checks++;
    if ({busy, diff} !== '0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b diff=%h, expected 0 0000", busy, diff);
    end
  endtask

  task automatic test_back_to_back;
    int   e, bh, g;
    res_t got, ex;
    issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    exp_q.push_back(model(16'hA5A5, 16'h5A5A, 1'b1, 1'b0));
    @(posedge clk); #1;
    wait_done(e, bh);
    got = {diff, bout, zero, overflow};
    ex  = exp_q.pop_front();
    checks++;
    if (got !== ex || e !== NN + 1) begin
      errors++;
      $display("FAIL b2b_first: got diff=%h bout=%b edges=%0d, expected diff=%h bout=%b edges=%0d",
               got.diff, got.bout, e, ex.diff, ex.bout, NN + 1);
    end
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (done !== 1'b1 && g < 20);
    start = 1'b0;
    checks++;
    if (g !== NN + 2) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles between results, expected %0d", g, NN + 2);
    end
    got = {diff, bout, zero, overflow};
    ex  = exp_q.pop_front();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL b2b_second: got diff=%h bout=%b zero=%b ovf=%b, expected diff=%h bout=%b zero=%b ovf=%b",
               got.diff, got.bout, got.zero, got.ovf, ex.diff, ex.bout, ex.zero, ex.ovf);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      test_single("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
  endtask

`ifdef NIBBLE_SUB_ADD_MODE_EN
  task automatic test_add_mode;
    test_single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    test_single("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    test_single("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_single("basic",     16'h1234, 16'h0234, 1'b0, 1'b0, 1'b1);
    test_single("wrap",      16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    test_single("overflow",  16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);
    test_single("zero",      16'h0010, 16'h000F, 1'b1, 1'b0, 1'b0);
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
`ifdef NIBBLE_SUB_ADD_MODE_EN
    test_add_mode();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
